// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: state and error encodings,
// frame geometry and checksum width.
package program_loader_pkg;

  localparam int unsigned HDR_BYTES       = 2;
  localparam int unsigned LEN_WIDTH       = HDR_BYTES * 8;
  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam int unsigned BIDX_WIDTH      = $clog2(BYTES_PER_INSTR);
  localparam int unsigned CHK_WIDTH       = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_LENGTH   = 2'b01,
    ERR_CHECKSUM = 2'b10,
    ERR_OPCODE   = 2'b11
  } err_code_t;

endpackage

// File: rtl/program_loader_instr_byte_assembler.sv
// Collects payload bytes MSB first into one instruction word, flags a
// non-zero opcode nibble on the first byte and pulses when a word is ready.
module instr_byte_assembler
  import program_loader_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 28
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_shift,
  input  logic [7:0]             i_byte,
  output logic                   o_last_byte,
  output logic                   o_nibble_err,
  output logic                   o_word_done,
  output logic [INSTR_WIDTH-1:0] o_word
);

  // Only the low INSTR_WIDTH bits of the 32-bit wire word survive, so the
  // history keeps just the bits that can still reach the assembled word;
  // byte 0's upper nibble is only needed for the immediate opcode check.
  localparam int unsigned HIST_W = INSTR_WIDTH - 8;

  logic [HIST_W-1:0]      r_hist;
  logic [BIDX_WIDTH-1:0]  r_idx;
  logic                   r_done;
  logic [INSTR_WIDTH-1:0] r_word;
  logic [INSTR_WIDTH-1:0] w_next;

  assign w_next       = {r_hist, i_byte};
  assign o_last_byte  = (r_idx == BIDX_WIDTH'(BYTES_PER_INSTR - 1));
  assign o_nibble_err = i_shift && (r_idx == '0) && (i_byte[7:4] != 4'h0);
  assign o_word_done  = r_done;
  assign o_word       = r_word;

  // Shift in accepted bytes; capture the word and pulse on the last byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hist <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
      r_word <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_clear) begin
        r_idx <= '0;
      end else if (i_shift) begin
        r_hist <= w_next[HIST_W-1:0];
        r_idx  <= r_idx + 1'b1;
        if (o_last_byte) begin
          r_done <= 1'b1;
          r_word <= w_next;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Instruction-memory writer: parses a length-prefixed, checksummed byte
// frame, writes each 28-bit instruction to RAM and holds the CPU in reset
// until a complete, verified program is present.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 28,
  parameter int unsigned MAX_WORDS   = 256
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iStart,
  input  logic [7:0]             iByte,
  input  logic                   iByteValid,
  output logic                   oByteReady,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddress,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic                   oCpuReset,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oError,
  output logic [1:0]             oErrorCode
);

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_len_hi;
  logic [LEN_WIDTH-1:0]  r_num_words;
  logic [LEN_WIDTH-1:0]  r_word_idx;
  logic [CHK_WIDTH-1:0]  r_chk;
  err_code_t             r_err;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_start;
  logic                  w_xfer;
  logic                  w_shift;
  logic [LEN_WIDTH-1:0]  w_len;
  logic                  w_len_bad;
  logic                  w_last_word;
  logic                  w_last_byte;
  logic                  w_nibble_err;
  logic                  w_word_done;

  assign w_start     = iStart && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign w_xfer      = iByteValid && oByteReady;
  assign w_shift     = w_xfer && (r_state == ST_DATA);
  assign w_len       = {r_len_hi, iByte};
  assign w_len_bad   = (w_len > LEN_WIDTH'(MAX_WORDS));
  assign w_last_word = (r_word_idx == (r_num_words - 1'b1));

  instr_byte_assembler #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_asm (
    .i_clk        (Clock),
    .i_rst_n      (Reset),
    .i_clear      (w_start),
    .i_shift      (w_shift),
    .i_byte       (iByte),
    .o_last_byte  (w_last_byte),
    .o_nibble_err (w_nibble_err),
    .o_word_done  (w_word_done),
    .o_word       (oInstruction)
  );

  // The strobe is masked by Reset so a reset landing on a strobe cycle
  // cannot commit that write at the same edge.
  assign oWriteEnable  = w_word_done && Reset;
  assign oWriteAddress = r_addr;
  assign oErrorCode    = r_err;

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode; every advance inside a session needs a byte transfer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: if (iStart) w_state_next = ST_HDR_HI;
      ST_HDR_HI: if (w_xfer) w_state_next = ST_HDR_LO;
      ST_HDR_LO: begin
        if (w_xfer) begin
          if (w_len_bad)        w_state_next = ST_ERROR;
          else if (w_len == '0) w_state_next = ST_CHECK;
          else                  w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_xfer) begin
          if (w_nibble_err)                    w_state_next = ST_ERROR;
          else if (w_last_byte && w_last_word) w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: if (w_xfer) w_state_next = (iByte == r_chk) ? ST_DONE : ST_ERROR;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Status and handshake outputs decoded from the current state.
  always_comb begin
    oByteReady = 1'b0;
    oBusy      = 1'b0;
    oDone      = 1'b0;
    oError     = 1'b0;
    oCpuReset  = 1'b1;
    case (r_state)
      ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CHECK: begin
        oByteReady = 1'b1;
        oBusy      = 1'b1;
      end
      ST_DONE:  begin
        oDone     = 1'b1;
        oCpuReset = 1'b0;
      end
      ST_ERROR: oError = 1'b1;
      default: ;
    endcase
  end

  // Length, word counter, checksum, error code and write address.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_len_hi    <= '0;
      r_num_words <= '0;
      r_word_idx  <= '0;
      r_chk       <= '0;
      r_err       <= ERR_NONE;
      r_addr      <= '0;
    end else if (w_start) begin
      r_len_hi    <= '0;
      r_num_words <= '0;
      r_word_idx  <= '0;
      r_chk       <= '0;
      r_err       <= ERR_NONE;
    end else if (w_xfer) begin
      case (r_state)
        ST_HDR_HI: r_len_hi <= iByte;
        ST_HDR_LO: begin
          r_num_words <= w_len;
          if (w_len_bad) r_err <= ERR_LENGTH;
        end
        ST_DATA: begin
          r_chk <= r_chk + iByte;
          if (w_nibble_err) begin
            r_err <= ERR_OPCODE;
          end else if (w_last_byte) begin
            r_addr <= ADDR_WIDTH'(r_word_idx);
            if (!w_last_word) r_word_idx <= r_word_idx + 1'b1;
          end
        end
        ST_CHECK: if (iByte != r_chk) r_err <= ERR_CHECKSUM;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the test plan
// plus randomized frames checked against a frame-level reference model.
module tb_program_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [43:0] wq_t[$];

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iStart = 1'b0;
  logic [7:0]  iByte = 8'h00;
  logic        iByteValid = 1'b0;
  logic        oByteReady, oWriteEnable, oCpuReset, oBusy, oDone, oError;
  logic [15:0] oWriteAddress;
  logic [27:0] oInstruction;
  logic [1:0]  oErrorCode;

  int checks = 0;
  int errors = 0;
  wq_t wr_q;

  always #5 Clock = ~Clock;

  program_loader #(
    .ADDR_WIDTH  (16),
    .INSTR_WIDTH (28),
    .MAX_WORDS   (256)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iStart        (iStart),
    .iByte         (iByte),
    .iByteValid    (iByteValid),
    .oByteReady    (oByteReady),
    .oWriteEnable  (oWriteEnable),
    .oWriteAddress (oWriteAddress),
    .oInstruction  (oInstruction),
    .oCpuReset     (oCpuReset),
    .oBusy         (oBusy),
    .oDone         (oDone),
    .oError        (oError),
    .oErrorCode    (oErrorCode)
  );

  // Record every RAM write strobe (one entry per high cycle).
  always @(negedge Clock) begin
    if (oWriteEnable === 1'b1) wr_q.push_back({oWriteAddress, oInstruction});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {done, error, code[1:0], cpu_reset, busy, byte_ready}
  function automatic logic [6:0] status();
    return {oDone, oError, oErrorCode, oCpuReset, oBusy, oByteReady};
  endfunction

  // Reference model: interpret a whole frame by the protocol rules.
  function automatic void model(input bq_t s, output wq_t w, output logic [6:0] st);
    int unsigned n, sum;
    logic [7:0]  b0;
    w = {};
    sum = 0;
    n = s[0] * 256 + s[1];
    if (n > 256) begin
      st = 7'b0101100;
      return;
    end
    for (int unsigned i = 0; i < n; i++) begin
      b0 = s[2 + 4*i];
      if (b0[7:4] != 4'h0) begin
        st = 7'b0111100;
        return;
      end
      w.push_back({16'(i), b0[3:0], s[3 + 4*i], s[4 + 4*i], s[5 + 4*i]});
      sum += s[2 + 4*i] + s[3 + 4*i] + s[4 + 4*i] + s[5 + 4*i];
    end
    if ((sum % 256) == s[2 + 4*n]) st = 7'b1000000;
    else                           st = 7'b0110100;
  endfunction

  // mode 0: valid frame, 1: corrupted checksum, 2: bad opcode nibble
  function automatic bq_t gen_frame(input int unsigned n, input int unsigned mode);
    bq_t         s;
    logic [15:0] nn;
    logic [7:0]  b, chk;
    int unsigned bad;
    s = {};
    nn = 16'(n);
    s.push_back(nn[15:8]);
    s.push_back(nn[7:0]);
    bad = (mode == 2 && n > 0) ? $urandom_range(0, n - 1) : n;
    chk = 8'h00;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        b = 8'($urandom);
        if (k == 0) b[7:4] = (i == bad) ? 4'($urandom_range(1, 15)) : 4'h0;
        s.push_back(b);
        chk = chk + b;
      end
    end
    if (mode == 1) chk = chk + 8'($urandom_range(1, 255));
    s.push_back(chk);
    return s;
  endfunction

  task automatic start_session();
    iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  // Offer bytes with random valid gaps; stop once the loader stops accepting.
  task automatic drive_frame(input bq_t s, input int unsigned gap_max, input bit poke);
    int last;
    last = s.size() - 1;
    for (int i = 0; i < s.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        iByteValid = 1'b0;
        iStart = 1'b0;
        @(negedge Clock);
      end
      iByteValid = 1'b1;
      iByte = s[i];
      iStart = (poke && i != last) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (oByteReady !== 1'b1) begin
        iByteValid = 1'b0;
        iStart = 1'b0;
        break;
      end
      @(negedge Clock);
    end
    iByteValid = 1'b0;
    iStart = 1'b0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic run_session(input bq_t s, input int unsigned gap_max, input bit poke,
                             output wq_t exp_w, output logic [6:0] exp_st,
                             output logic [6:0] st_started);
    wr_q.delete();
    start_session();
    st_started = status();
    drive_frame(s, gap_max, poke);
    model(s, exp_w, exp_st);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if (status() !== 7'b0000100) begin
      errors++; $display("FAIL reset_status: got %b expected %b", status(), 7'b0000100);
    end
    checks++;
    if ({oWriteEnable, oWriteAddress, oInstruction} !== 45'd0) begin
      errors++; $display("FAIL reset_write_port: got we=%b addr=%h data=%h expected zeros",
                         oWriteEnable, oWriteAddress, oInstruction);
    end
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if (status() !== 7'b0000100) begin
      errors++; $display("FAIL idle_reset_status: got %b expected %b", status(), 7'b0000100);
    end
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (status() !== 7'b0000100) begin
      errors++; $display("FAIL idle_after_reset: got %b expected %b", status(), 7'b0000100);
    end
  endtask

  task automatic test_good_frame();
    bq_t s;
    wq_t exp_w;
    logic [6:0] exp_st, st0;
    s = {8'h00, 8'h02, 8'h01, 8'h03, 8'h00, 8'h05, 8'h02, 8'h04, 8'h01, 8'h02, 8'h12};
    run_session(s, 0, 1'b0, exp_w, exp_st, st0);
    checks++;
    if (st0 !== 7'b0000111) begin
      errors++; $display("FAIL good_start_status: got %b expected %b", st0, 7'b0000111);
    end
    checks++;
    if (wr_q.size() != exp_w.size()) begin
      errors++; $display("FAIL good_write_count: got %0d expected %0d", wr_q.size(), exp_w.size());
    end
    foreach (exp_w[i]) if (i < wr_q.size()) begin
      checks++;
      if (wr_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL good_write[%0d]: got %h expected %h", i, wr_q[i], exp_w[i]);
      end
    end
    checks++;
    if (status() !== exp_st) begin
      errors++; $display("FAIL good_status: got %b expected %b", status(), exp_st);
    end
  endtask

  task automatic test_bad_checksum();
    bq_t s;
    wq_t exp_w;
    logic [6:0] exp_st, st0;
    s = {8'h00, 8'h02, 8'h01, 8'h03, 8'h00, 8'h05, 8'h02, 8'h04, 8'h01, 8'h02, 8'h13};
    run_session(s, 2, 1'b0, exp_w, exp_st, st0);
    checks++;
    if (st0 !== 7'b0000111) begin
      errors++; $display("FAIL chk_restart_status: got %b expected %b", st0, 7'b0000111);
    end
    checks++;
    if (wr_q.size() != exp_w.size()) begin
      errors++; $display("FAIL chk_write_count: got %0d expected %0d", wr_q.size(), exp_w.size());
    end
    foreach (exp_w[i]) if (i < wr_q.size()) begin
      checks++;
      if (wr_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL chk_write[%0d]: got %h expected %h", i, wr_q[i], exp_w[i]);
      end
    end
    checks++;
    if (status() !== exp_st) begin
      errors++; $display("FAIL chk_status: got %b expected %b", status(), exp_st);
    end
  endtask

  task automatic test_length_and_opcode();
    bq_t s;
    wq_t exp_w;
    logic [6:0] exp_st, st0;
    s = {8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    run_session(s, 1, 1'b0, exp_w, exp_st, st0);
    checks++;
    if (wr_q.size() != 0) begin
      errors++; $display("FAIL len_write_count: got %0d expected 0", wr_q.size());
    end
    checks++;
    if (status() !== exp_st) begin
      errors++; $display("FAIL len_status: got %b expected %b", status(), exp_st);
    end
    s = {8'h00, 8'h01, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h1F};
    run_session(s, 1, 1'b0, exp_w, exp_st, st0);
    checks++;
    if (wr_q.size() != 0) begin
      errors++; $display("FAIL opc_write_count: got %0d expected 0", wr_q.size());
    end
    checks++;
    if (status() !== exp_st) begin
      errors++; $display("FAIL opc_status: got %b expected %b", status(), exp_st);
    end
  endtask

  task automatic test_reset_midframe();
    bq_t s;
    wq_t exp_w;
    logic [6:0] exp_st, st0;
    wr_q.delete();
    start_session();
    s = {8'h00, 8'h01, 8'h0F, 8'hFF};
    drive_frame(s, 3, 1'b0);
    Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if (status() !== 7'b0000100) begin
      errors++; $display("FAIL midreset_status: got %b expected %b", status(), 7'b0000100);
    end
    checks++;
    if (wr_q.size() != 0 || {oWriteEnable, oWriteAddress, oInstruction} !== 45'd0) begin
      errors++; $display("FAIL midreset_write: got count=%0d addr=%h data=%h expected 0",
                         wr_q.size(), oWriteAddress, oInstruction);
    end
    Reset = 1'b1;
    @(negedge Clock);
    s = {8'h00, 8'h01, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'h0C};
    run_session(s, 0, 1'b0, exp_w, exp_st, st0);
    checks++;
    if (wr_q.size() != exp_w.size()) begin
      errors++; $display("FAIL reload_write_count: got %0d expected %0d", wr_q.size(), exp_w.size());
    end
    foreach (exp_w[i]) if (i < wr_q.size()) begin
      checks++;
      if (wr_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL reload_write[%0d]: got %h expected %h", i, wr_q[i], exp_w[i]);
      end
    end
    checks++;
    if (status() !== exp_st) begin
      errors++; $display("FAIL reload_status: got %b expected %b", status(), exp_st);
    end
  endtask

  task automatic test_boundaries();
    bq_t s;
    wq_t exp_w;
    logic [6:0] exp_st, st0;
    logic [43:0] last_w;
    int unsigned sizes[3] = '{256, 0, 0};
    int unsigned modes[3] = '{0, 0, 1};
    for (int t = 0; t < 3; t++) begin
      s = gen_frame(sizes[t], modes[t]);
      run_session(s, 0, 1'b1, exp_w, exp_st, st0);
      checks++;
      if (wr_q.size() != exp_w.size()) begin
        errors++; $display("FAIL bound%0d_write_count: got %0d expected %0d", t, wr_q.size(), exp_w.size());
      end
      foreach (exp_w[i]) if (i < wr_q.size()) begin
        checks++;
        if (wr_q[i] !== exp_w[i]) begin
          errors++; $display("FAIL bound%0d_write[%0d]: got %h expected %h", t, i, wr_q[i], exp_w[i]);
        end
      end
      checks++;
      if (status() !== exp_st) begin
        errors++; $display("FAIL bound%0d_status: got %b expected %b", t, status(), exp_st);
      end
      if (t == 0) begin
        last_w = exp_w[exp_w.size() - 1];
        checks++;
        if (oWriteAddress !== last_w[43:28]) begin
          errors++; $display("FAIL addr_hold: got %h expected %h", oWriteAddress, last_w[43:28]);
        end
      end
    end
  endtask

  task automatic test_random();
    bq_t s;
    wq_t exp_w;
    logic [6:0] exp_st, st0;
    for (int it = 0; it < 12; it++) begin
      s = gen_frame($urandom_range(1, 8), $urandom_range(0, 2));
      run_session(s, $urandom_range(0, 3), 1'($urandom_range(0, 1)), exp_w, exp_st, st0);
      checks++;
      if (st0 !== 7'b0000111) begin
        errors++; $display("FAIL rnd%0d_start_status: got %b expected %b", it, st0, 7'b0000111);
      end
      checks++;
      if (wr_q.size() != exp_w.size()) begin
        errors++; $display("FAIL rnd%0d_write_count: got %0d expected %0d", it, wr_q.size(), exp_w.size());
      end
      foreach (exp_w[i]) if (i < wr_q.size()) begin
        checks++;
        if (wr_q[i] !== exp_w[i]) begin
          errors++; $display("FAIL rnd%0d_write[%0d]: got %h expected %h", it, i, wr_q[i], exp_w[i]);
        end
      end
      checks++;
      if (status() !== exp_st) begin
        errors++; $display("FAIL rnd%0d_status: got %b expected %b", it, status(), exp_st);
      end
    end
  endtask

  initial begin
    @(negedge Clock);
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length_and_opcode();
    test_reset_midframe();
    test_boundaries();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction memory: receives a framed byte stream, assembles 28-bit instructions and writes them into a writable instruction RAM at consecutive addresses.
- Holds the MiniAlu core in reset while loading. Releases it only after a complete, checksum-verified program has been written.
- Sits between a byte source (UART RX or test host) and the instruction RAM write port / CPU reset input.

Parameters:
- ADDR_WIDTH, 16, width of the instruction address (matches the CPU instruction pointer).
- INSTR_WIDTH, 28, instruction width; fixed at 4 bytes per instruction on the wire.
- MAX_WORDS, 256, largest accepted word count N; valid range is 0..MAX_WORDS.

Ports:
- Clock  in  1  system clock; all logic is on the posedge.
- Reset  in  1  synchronous, active-low reset (Reset=0 at a posedge resets the block).
- iStart  in  1  starts a load session; sampled in IDLE, DONE and ERROR only.
- iByte  in  8  stream data byte.
- iByteValid  in  1  iByte is valid.
- oByteReady  out  1  loader accepts a byte; transfer = iByteValid & oByteReady at the posedge.
- oWriteEnable  out  1  one-cycle write strobe to the instruction RAM.
- oWriteAddress  out  ADDR_WIDTH  RAM write address.
- oInstruction  out  INSTR_WIDTH  RAM write data.
- oCpuReset  out  1  active-high reset to the CPU core.
- oBusy  out  1  a session is in progress.
- oDone  out  1  last load succeeded; level output.
- oError  out  1  last load failed; level output.
- oErrorCode  out  2  01 = length, 10 = checksum, 11 = bad opcode nibble, 00 = none.

Behaviour:
- Reset values:
  - oByteReady=0, oWriteEnable=0, oWriteAddress=0, oInstruction=0.
  - oCpuReset=1, oBusy=0, oDone=0, oError=0, oErrorCode=00.
  - State goes to IDLE; byte counter, word counter and checksum are cleared.
- Frame format:
  - Header: N[15:8], then N[7:0].
  - Payload: N instructions, 4 bytes each, most significant byte first. Bits [7:4] of byte 0 must be 0; the instruction is {byte0[3:0], byte1, byte2, byte3}.
  - Trailer: CHK = (sum of all payload bytes) mod 256. Header bytes are not summed.
- States: IDLE, HDR_HI, HDR_LO, DATA, CHECK, DONE, ERROR.
- oByteReady=1 only in HDR_HI, HDR_LO, DATA and CHECK. A state advances only on a transfer; iByteValid gaps stall the block with no side effects.
- IDLE:
  - iStart moves to HDR_HI.
  - Entering HDR_HI clears the counters and checksum, clears oDone, oError and oErrorCode, and sets oCpuReset=1 and oBusy=1.
- HDR_HI: a transfer latches N[15:8] and moves to HDR_LO.
- HDR_LO: a transfer latches N[7:0], then:
  - N > MAX_WORDS: go to ERROR, code 01.
  - N == 0: go to CHECK.
  - Otherwise: go to DATA.
- DATA:
  - Each transfer shifts the byte into the assembler and adds it to the checksum. A 2-bit byte index wraps 3→0.
  - Byte index 0 with iByte[7:4] != 0: go to ERROR, code 11, in the cycle after the transfer; no write happens.
  - The cycle after byte index 3 is accepted: oWriteEnable=1 for exactly one cycle, with oWriteAddress = word index and oInstruction = assembled word. The word index then increments.
  - After word N-1 is written, go to CHECK.
  - Back-to-back bytes are accepted with no bubble; the write pulse overlaps acceptance of the next byte.
- CHECK: a transfer compares the byte with the checksum.
  - Match: go to DONE.
  - Mismatch: go to ERROR, code 10.
- DONE:
  - oDone=1, oCpuReset=0, oBusy=0.
  - These outputs change in the cycle after the CHK transfer.
- ERROR:
  - oError=1, oCpuReset=1, oBusy=0.
  - RAM words already written are not rolled back.
- DONE or ERROR: iStart starts a new session (HDR_HI) and reasserts oCpuReset in the next cycle.
- iStart outside IDLE, DONE and ERROR is ignored.
- Reset=0 in any state, including in the same cycle as a write: the write is suppressed, all outputs take their reset values, and the block returns to IDLE.
- oWriteAddress holds its last value between strobes. The address width is ADDR_WIDTH; the word index never exceeds MAX_WORDS-1.

Decomposition:
- Shared definitions include:
  - State encodings (3 bits).
  - Error codes.
  - Header length (2) and bytes-per-instruction (4).
  - Checksum width (8).
- Sub-module instr_byte_assembler:
  - Contents: 32-bit shift register, 2-bit byte index, word-complete pulse and opcode-nibble check.
  - Top level keeps the FSM, counters and checksum.

Test Plan:
- Reset held 0 for 2 cycles mid-idle → all outputs at reset values, oCpuReset=1, oByteReady=0.
- iStart, stream 00 02 | 01 03 00 05 | 02 04 01 02 | 12 → writes addr0=0x1030005 and addr1=0x2040102, one strobe each; oDone=1, oCpuReset=0, oErrorCode=00.
- Same payload with CHK=13 → both writes occur, then oError=1, oErrorCode=10, oCpuReset stays 1.
- Header 01 01 (N=257, MAX_WORDS=256) → ERROR with code 01 right after the header; zero write strobes.
- Header 00 01, then first byte 1F → ERROR with code 11; no write.
- N=1, first 2 payload bytes sent with random iByteValid gaps, then Reset=0 → IDLE with no write. Then iStart and stream 00 01 | 0F FF FF FF | 0C → one write of 0xFFFFFFF at addr0; DONE.
